// File: rtl/sm510_input_matrix_pkg.sv
// sm510_input_pkg: mapping-entry layout, source/target encodings and strobe decode shared by the input matrix.
package sm510_input_pkg;

    localparam int ENT_EN      = 7;
    localparam int ENT_SRC     = 6;
    localparam int ENT_IDX_MSB = 5;
    localparam int ENT_IDX_LSB = 3;
    localparam int ENT_TGT_MSB = 2;
    localparam int ENT_TGT_LSB = 0;

    typedef enum logic {
        SRC_S = 1'b0,
        SRC_R = 1'b1
    } src_e;

    typedef enum logic [2:0] {
        TGT_K0   = 3'd0,
        TGT_K1   = 3'd1,
        TGT_K2   = 3'd2,
        TGT_K3   = 3'd3,
        TGT_BA   = 3'd4,
        TGT_BETA = 3'd5
    } tgt_e;

    // R has only four lines, so R strobe indices 4-7 can never be driven by the CPU
    function automatic logic strobe_match(input logic src, input logic [2:0] idx,
                                          input logic [7:0] s, input logic [3:0] r);
        return (src == SRC_R) ? (!idx[2] && r[idx[1:0]]) : s[idx];
    endfunction

endpackage

// File: rtl/sm510_input_matrix_if.sv
// sm510_input_matrix_if: key-scan bus between the sm510 core (strobes) and the input matrix (K/BA/beta).
interface sm510_input_matrix_if;

    logic [7:0] shifter_s;
    logic [3:0] output_r;
    logic [3:0] input_k;
    logic       input_ba;
    logic       input_beta;

    modport master (
        output shifter_s,
        output output_r,
        input  input_k,
        input  input_ba,
        input  input_beta
    );

    modport slave (
        input  shifter_s,
        input  output_r,
        output input_k,
        output input_ba,
        output input_beta
    );

endinterface

// File: rtl/sm510_input_matrix_debounce.sv
// input_debounce: 2-FF synchronizer plus stable-count debouncer for one raw button level.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic state
);

    logic [1:0] sync;

    // two-stage synchronizer, sync[1] is the metastability-safe copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], raw};
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign state = sync[1];
        end else begin : g_count
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            logic [CW-1:0] cnt;
            // flip on the DEBOUNCE_CYCLES-th consecutive differing cycle; any agreement restarts the count
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt   <= '0;
                    state <= 1'b0;
                end else if (sync[1] == state) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= ~state;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sm510_input_matrix.sv
// sm510_input_matrix: routes debounced buttons onto SM510 K/BA/beta through a runtime-loaded mapping table.
module sm510_input_matrix
    import sm510_input_pkg::*;
#(
    parameter int BUTTON_COUNT    = 16,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [BUTTON_COUNT-1:0] buttons,
    input  logic                    cfg_wr,
    input  logic [3:0]              cfg_index,
    input  logic [7:0]              cfg_data,
    sm510_input_matrix_if.slave     bus,
    output logic                    pressed_any
);

    localparam int IW = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;

    logic [7:0]              map [BUTTON_COUNT];
    logic [BUTTON_COUNT-1:0] db;
    logic [BUTTON_COUNT-1:0] live;
    logic [BUTTON_COUNT-1:0] hit;
    logic [3:0]              k_nxt;
    logic                    ba_nxt;
    logic                    beta_nxt;

    genvar i;
    generate
        for (i = 0; i < BUTTON_COUNT; i++) begin : g_btn
            input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (buttons[i]),
                .state   (db[i])
            );
            assign live[i] = map[i][ENT_EN] & db[i];
            assign hit[i]  = live[i] & strobe_match(map[i][ENT_SRC], map[i][ENT_IDX_MSB:ENT_IDX_LSB],
                                                    bus.shifter_s, bus.output_r);
        end
    endgenerate

    // mapping table; out-of-range indices are dropped rather than aliased
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < BUTTON_COUNT; j++) map[j] <= '0;
        end else if (cfg_wr && ({1'b0, cfg_index} < 5'(BUTTON_COUNT))) begin
            map[cfg_index[IW-1:0]] <= cfg_data;
        end
    end

    // OR every live entry into its target; BA/beta ignore the strobe fields, reserved targets add nothing
    always_comb begin
        k_nxt    = '0;
        ba_nxt   = 1'b0;
        beta_nxt = 1'b0;
        for (int j = 0; j < BUTTON_COUNT; j++) begin
            k_nxt    = k_nxt | ({3'b000, hit[j] & ~map[j][ENT_TGT_MSB]} << map[j][ENT_TGT_MSB-1:ENT_TGT_LSB]);
            ba_nxt   = ba_nxt | (live[j] && (map[j][ENT_TGT_MSB:ENT_TGT_LSB] == TGT_BA));
            beta_nxt = beta_nxt | (live[j] && (map[j][ENT_TGT_MSB:ENT_TGT_LSB] == TGT_BETA));
        end
    end

    // registered outputs towards the core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.input_k    <= '0;
            bus.input_ba   <= 1'b0;
            bus.input_beta <= 1'b0;
            pressed_any    <= 1'b0;
        end else begin
            bus.input_k    <= k_nxt;
            bus.input_ba   <= ba_nxt;
            bus.input_beta <= beta_nxt;
            pressed_any    <= |db;
        end
    end

endmodule

// File: tb/tb_sm510_input_matrix.sv
// tb_sm510_input_matrix: scenario tests plus randomized mapping/strobe checks against a table-walk reference model.
module tb_sm510_input_matrix;

    localparam int BC = 8;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] buttons = '0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_index = '0;
    logic [7:0] cfg_data = '0;
    logic       pressed_any;

    int checks = 0;
    int errors = 0;

    logic [7:0]    mdl_map [BC];
    logic [BC-1:0] mdl_btn;

    sm510_input_matrix_if bus();

    sm510_input_matrix #(.BUTTON_COUNT(BC), .DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buttons     (buttons),
        .cfg_wr      (cfg_wr),
        .cfg_index   (cfg_index),
        .cfg_data    (cfg_data),
        .bus         (bus.slave),
        .pressed_any (pressed_any)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] observed();
        return {pressed_any, bus.input_beta, bus.input_ba, bus.input_k};
    endfunction

    // walk the table: a pressed, enabled button drives its target if its strobe is live
    function automatic logic [6:0] model(input logic [7:0] s, input logic [3:0] r);
        logic [3:0] k;
        logic       ba;
        logic       beta;
        logic [2:0] idx;
        logic [2:0] tgt;
        logic       on;
        k = '0;
        ba = 1'b0;
        beta = 1'b0;
        for (int n = 0; n < BC; n++) begin
            if (mdl_map[n][7] && mdl_btn[n]) begin
                idx = mdl_map[n][5:3];
                tgt = mdl_map[n][2:0];
                on = mdl_map[n][6] ? ((idx < 4) ? r[idx[1:0]] : 1'b0) : s[idx];
                if (tgt < 4 && on) k[tgt[1:0]] = 1'b1;
                if (tgt == 4) ba = 1'b1;
                if (tgt == 5) beta = 1'b1;
            end
        end
        return {|mdl_btn, beta, ba, k};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        buttons = '0;
        cfg_wr = 1'b0;
        bus.shifter_s = '0;
        bus.output_r = '0;
        tick(2);
        reset_n = 1'b1;
        for (int n = 0; n < BC; n++) mdl_map[n] = '0;
        mdl_btn = '0;
        tick(1);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [7:0] data);
        cfg_wr = 1'b1;
        cfg_index = idx;
        cfg_data = data;
        tick(1);
        cfg_wr = 1'b0;
        if (idx < BC) mdl_map[idx[2:0]] = data;
    endtask

    task automatic press(input logic [7:0] b);
        buttons = b;
        tick(DC + 4);
        mdl_btn = b;
    endtask

    task automatic test_reset();
        buttons = 8'hFF;
        bus.shifter_s = 8'hFF;
        bus.output_r = 4'hF;
        #1 reset_n = 1'b0;
        tick(3);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL reset_k got %h exp 0", bus.input_k); end
        checks++;
        if (bus.input_ba !== 1'b0) begin errors++; $display("FAIL reset_ba got %b exp 0", bus.input_ba); end
        checks++;
        if (bus.input_beta !== 1'b0) begin errors++; $display("FAIL reset_beta got %b exp 0", bus.input_beta); end
        checks++;
        if (pressed_any !== 1'b0) begin errors++; $display("FAIL reset_pressed_any got %b exp 0", pressed_any); end
    endtask

    task automatic test_r3_scan();
        reset_dut();
        cfg_write(4'd0, 8'hDA);
        press(8'h01);
        bus.output_r = 4'b1000;
        tick(1);
        checks++;
        if (bus.input_k !== 4'h4) begin errors++; $display("FAIL r3_scan_on got %h exp 4", bus.input_k); end
        checks++;
        if (pressed_any !== 1'b1) begin errors++; $display("FAIL r3_pressed_any got %b exp 1", pressed_any); end
        bus.output_r = 4'b0000;
        tick(1);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL r3_scan_off got %h exp 0", bus.input_k); end
    endtask

    task automatic test_s_scan();
        cfg_write(4'd0, 8'h89);
        cfg_write(4'd1, 8'h92);
        cfg_write(4'd2, 8'h91);
        bus.output_r = 4'h0;
        press(8'h06);
        bus.shifter_s = 8'h04;
        tick(1);
        checks++;
        if (bus.input_k !== 4'h6) begin errors++; $display("FAIL s2_scan got %h exp 6", bus.input_k); end
        checks++;
        if (observed() !== model(8'h04, 4'h0)) begin errors++; $display("FAIL s2_model got %h exp %h", observed(), model(8'h04, 4'h0)); end
        bus.shifter_s = 8'h02;
        tick(1);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL s1_scan got %h exp 0", bus.input_k); end
        press(8'h07);
        bus.shifter_s = 8'h06;
        tick(1);
        checks++;
        if (bus.input_k !== 4'h6) begin errors++; $display("FAIL s12_scan got %h exp 6", bus.input_k); end
    endtask

    task automatic test_debounce();
        int bad;
        int lat;
        reset_dut();
        cfg_write(4'd0, 8'hDA);
        bus.output_r = 4'b1000;
        tick(8);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL deb_idle got %h exp 0", bus.input_k); end
        bad = 0;
        buttons = 8'h01;
        for (int t = 0; t < 15; t++) begin
            if (t == 3) buttons = 8'h00;
            tick(1);
            if (bus.input_k !== 4'h0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL deb_short_pulse got %0d asserted cycles exp 0", bad); end
        buttons = 8'h01;
        lat = 0;
        for (int t = 1; t <= 20 && lat == 0; t++) begin
            tick(1);
            if (bus.input_k === 4'h4) lat = t;
        end
        checks++;
        if (lat != 7) begin errors++; $display("FAIL deb_latency got %0d exp 7", lat); end
        tick(2);
        bad = 0;
        buttons = 8'h00;
        for (int t = 0; t < 15; t++) begin
            if (t == 3) buttons = 8'h01;
            tick(1);
            if (bus.input_k !== 4'h4) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL deb_release_glitch got %0d dropped cycles exp 0", bad); end
        buttons = 8'h00;
        tick(8);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL deb_release got %h exp 0", bus.input_k); end
    endtask

    task automatic test_direct();
        reset_dut();
        cfg_write(4'd3, 8'h84);
        cfg_write(4'd4, 8'h85);
        press(8'h18);
        checks++;
        if (bus.input_ba !== 1'b1) begin errors++; $display("FAIL direct_ba got %b exp 1", bus.input_ba); end
        checks++;
        if (bus.input_beta !== 1'b1) begin errors++; $display("FAIL direct_beta got %b exp 1", bus.input_beta); end
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL direct_k got %h exp 0", bus.input_k); end
        press(8'h08);
        checks++;
        if ({bus.input_beta, bus.input_ba} !== 2'b01) begin errors++; $display("FAIL direct_ba_only got %b exp 01", {bus.input_beta, bus.input_ba}); end
    endtask

    task automatic test_invalid_cfg();
        reset_dut();
        press(8'h80);
        cfg_write(4'hF, 8'h84);
        for (int n = BC; n < 15; n++) cfg_write(4'(n), 8'h80 | 8'($urandom));
        bus.shifter_s = 8'hFF;
        bus.output_r = 4'hF;
        tick(1);
        checks++;
        if (bus.input_ba !== 1'b0) begin errors++; $display("FAIL inv_index_ba got %b exp 0", bus.input_ba); end
        checks++;
        if (observed() !== model(8'hFF, 4'hF)) begin errors++; $display("FAIL inv_index_all got %h exp %h", observed(), model(8'hFF, 4'hF)); end
        cfg_write(4'd7, 8'h86);
        tick(1);
        checks++;
        if (observed() !== 7'h40) begin errors++; $display("FAIL inv_target6 got %h exp 40", observed()); end
        cfg_write(4'd7, 8'hE8);
        tick(1);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL inv_r_strobe5 got %h exp 0", bus.input_k); end
        cfg_write(4'd7, 8'hD8);
        tick(1);
        checks++;
        if (bus.input_k !== 4'h1) begin errors++; $display("FAIL r_strobe3_k0 got %h exp 1", bus.input_k); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] s;
        logic [3:0] r;
        reset_dut();
        repeat (30) begin
            b = 8'($urandom);
            buttons = b;
            for (int n = 0; n < BC; n++) begin
                d = 8'($urandom);
                d[7] = ($urandom_range(3) != 0);
                cfg_write(4'(n), d);
            end
            tick(1);
            mdl_btn = b;
            repeat (4) begin
                s = 8'($urandom);
                r = 4'($urandom);
                bus.shifter_s = s;
                bus.output_r = r;
                tick(1);
                checks++;
                if (observed() !== model(s, r)) begin
                    errors++;
                    $display("FAIL random s=%h r=%h btn=%h got %h exp %h", s, r, b, observed(), model(s, r));
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        reset_dut();
        cfg_write(4'd0, 8'hDA);
        bus.output_r = 4'b1000;
        press(8'h01);
        checks++;
        if (bus.input_k !== 4'h4) begin errors++; $display("FAIL midrst_pre got %h exp 4", bus.input_k); end
        reset_n = 1'b0;
        #2;
        checks++;
        if (observed() !== 7'h00) begin errors++; $display("FAIL midrst_async got %h exp 00", observed()); end
        tick(2);
        reset_n = 1'b1;
        for (int n = 0; n < BC; n++) mdl_map[n] = '0;
        tick(10);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL midrst_cleared_k got %h exp 0", bus.input_k); end
        checks++;
        if (pressed_any !== 1'b1) begin errors++; $display("FAIL midrst_pressed_any got %b exp 1", pressed_any); end
        cfg_write(4'd0, 8'hDA);
        checks++;
        if (bus.input_k !== 4'h0) begin errors++; $display("FAIL cfg_old_value got %h exp 0", bus.input_k); end
        tick(1);
        checks++;
        if (bus.input_k !== 4'h4) begin errors++; $display("FAIL cfg_new_value got %h exp 4", bus.input_k); end
    endtask

    initial begin
        bus.shifter_s = '0;
        bus.output_r = '0;
        test_reset();
        test_r3_scan();
        test_s_scan();
        test_debounce();
        test_direct();
        test_invalid_cfg();
        test_random();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
